regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources: ALU results and load-return data from the memory stage.
- Each source has its own FIFO. A round-robin arbiter drains the FIFO heads at one write per cycle onto registered wen/w_addr/w_data.
- Exports busy_mask so the issue/hazard logic can stall on registers that still have queued writes.

---
 rtl/regfile_write_arbiter.sv | 177 +++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: per-source FIFOs (ALU, MEM), round-robin
// drain at one write per cycle onto registered wen/w_addr/w_data, plus a
// pending-write mask for the hazard logic.

// Per-source write queue; also reports which registers it holds writes for.
module rfwa_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [ADDR_W-1:0]      push_addr,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   pop,
  output logic [ADDR_W-1:0]      head_addr,
  output logic [DATA_W-1:0]      head_data,
  output logic                   nonempty,
  output logic                   not_full,
  output logic [(1<<ADDR_W)-1:0] mask
);
  localparam int PW = $clog2(QDEPTH);

  logic [ADDR_W-1:0] addr_q [QDEPTH];
  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, offs;
  logic [PW:0]       count;

  // Pointer/count bookkeeping; flush drops every queued entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign nonempty  = (count != '0);
  assign not_full  = (count < (PW+1)'(QDEPTH));

  // Destination mask over the occupied slots (distance from head < count).
  always_comb begin
    mask = '0;
    offs = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if ({1'b0, offs} < count) mask[addr_q[i]] = 1'b1;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int QDEPTH         = 4,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   wen,
  output logic [ADDR_W-1:0]      w_addr,
  output logic [DATA_W-1:0]      w_data,
  output logic [(1<<ADDR_W)-1:0] busy_mask
);
  localparam int NREG = 1 << ADDR_W;
  localparam int NSRC = 2;  // index 0 = ALU, 1 = MEM

  logic [NSRC-1:0]             in_valid, ready, push, pop, nonempty, not_full;
  logic [NSRC-1:0][ADDR_W-1:0] in_addr, head_addr;
  logic [NSRC-1:0][DATA_W-1:0] in_data, head_data;
  logic [NSRC-1:0][NREG-1:0]   q_mask;
  logic                        last_grant, grant_valid, grant_sel, drop_zero;
  logic [ADDR_W-1:0]           g_addr;
  logic [DATA_W-1:0]           g_data;

  assign in_valid  = {mem_valid, alu_valid};
  assign in_addr   = {mem_addr, alu_addr};
  assign in_data   = {mem_data, alu_data};
  assign ready     = not_full & {NSRC{~flush}};
  assign push      = in_valid & ready;
  assign alu_ready = ready[0];
  assign mem_ready = ready[1];

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    rfwa_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push[s]),
      .push_addr (in_addr[s]),
      .push_data (in_data[s]),
      .pop       (pop[s]),
      .head_addr (head_addr[s]),
      .head_data (head_data[s]),
      .nonempty  (nonempty[s]),
      .not_full  (not_full[s]),
      .mask      (q_mask[s])
    );
  end

  // Round-robin pick: a lone non-empty head wins; on contention, the side
  // opposite the last contended winner.
  always_comb begin
    grant_valid = |nonempty;
    if (&nonempty) grant_sel = ~last_grant;
    else           grant_sel = nonempty[1];
    pop = '0;
    if (grant_valid && !flush) pop[grant_sel] = 1'b1;
  end

  assign g_addr    = head_addr[grant_sel];
  assign g_data    = head_data[grant_sel];
  assign drop_zero = (ZERO_HARDWIRED != 0) && (g_addr == '0);

  // Fairness pointer only moves on contention; flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     last_grant <= 1'b1;
    else if (!flush && &nonempty) last_grant <= grant_sel;
  end

  // Registered write port; address-0 writes are popped but never enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen    <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else if (flush) begin
      wen <= 1'b0;
    end else begin
      wen <= grant_valid && !drop_zero;
      if (grant_valid) begin
        w_addr <= g_addr;
        w_data <= g_data;
      end
    end
  end

  // Pending-write mask: everything queued plus the write being presented.
  always_comb begin
    busy_mask = q_mask[0] | q_mask[1];
    if (wen) busy_mask[w_addr] = 1'b1;
    if (ZERO_HARDWIRED != 0) busy_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized + directed bench for regfile_write_arbiter against a queue-level model.
module tb_regfile_write_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int QDEPTH = 4;
  localparam int ZH     = 1;
  localparam int NREG   = 1 << ADDR_W;
  localparam int VW     = 3 + ADDR_W + DATA_W + NREG;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic [ADDR_W-1:0] alu_addr = '0, mem_addr = '0;
  logic [DATA_W-1:0] alu_data = '0, mem_data = '0;
  logic alu_ready, mem_ready, wen;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [NREG-1:0]   busy_mask;
  logic [VW-1:0]     obs;

  int checks = 0, failures = 0;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH),
                          .ZERO_HARDWIRED(ZH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .wen(wen), .w_addr(w_addr), .w_data(w_data), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  assign obs = {alu_ready, mem_ready, wen, w_addr, w_data, busy_mask};

  // Model: pending writes per source as queues of {addr,data}; output register.
  logic [ADDR_W+DATA_W-1:0] aq[$], mq[$];
  int                m_last;  // 0 = ALU, 1 = MEM won the last contention
  logic              m_wen;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;

  task automatic model_reset();
    aq.delete(); mq.delete();
    m_last = 1; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [NREG-1:0] b = '0;
    foreach (aq[i]) b[aq[i][ADDR_W+DATA_W-1:DATA_W]] = 1'b1;
    foreach (mq[i]) b[mq[i][ADDR_W+DATA_W-1:DATA_W]] = 1'b1;
    if (m_wen) b[m_waddr] = 1'b1;
    if (ZH != 0) b[0] = 1'b0;
    return {aq.size() < QDEPTH && !flush, mq.size() < QDEPTH && !flush,
            m_wen, m_waddr, m_wdata, b};
  endfunction

  // Apply one cycle of inputs (from a negedge), advance DUT and model, end on negedge.
  task automatic step(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                      input logic fl);
    bit a_acc, m_acc, both;
    int g;
    logic [ADDR_W+DATA_W-1:0] e;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    flush = fl;
    a_acc = av && (aq.size() < QDEPTH) && !fl;
    m_acc = mv && (mq.size() < QDEPTH) && !fl;
    both  = (aq.size() > 0) && (mq.size() > 0);
    if (both)               g = (m_last == 1) ? 0 : 1;
    else if (aq.size() > 0) g = 0;
    else if (mq.size() > 0) g = 1;
    else                    g = -1;
    @(posedge clk);
    if (fl) begin
      aq.delete(); mq.delete(); m_wen = 1'b0;
    end else begin
      m_wen = 1'b0;
      if (g >= 0) begin
        e = (g == 0) ? aq.pop_front() : mq.pop_front();
        m_waddr = e[ADDR_W+DATA_W-1:DATA_W];
        m_wdata = e[DATA_W-1:0];
        m_wen   = !((ZH != 0) && (m_waddr == '0));
        if (both) m_last = g;
      end
      if (a_acc) aq.push_back({aa, ad});
      if (m_acc) mq.push_back({ma, md});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    logic [VW-1:0] rst_exp;
    rst = 1'b0; alu_valid = 1'b1; alu_addr = 5'd5; mem_valid = 1'b1; mem_addr = 5'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_exp = {1'b1, 1'b1, 1'b0, {ADDR_W{1'b0}}, {DATA_W{1'b0}}, {NREG{1'b0}}};
    checks++;
    if (obs !== rst_exp) begin
      failures++; $display("FAIL reset_hold actual=%h required=%h", obs, rst_exp);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (obs !== exp_vec() || wen !== 1'b0) begin
        failures++; $display("FAIL reset_after c%0d actual=%h required=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_single();
    step(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
    checks++;
    if (wen !== 1'b0 || busy_mask[7] !== 1'b1 || obs !== exp_vec()) begin
      failures++; $display("FAIL single_queued actual=%h required=%h", obs, exp_vec());
    end
    idle();
    checks++;
    if (wen !== 1'b1 || w_addr !== 5'd7 || w_data !== 32'hDEADBEEF || busy_mask[7] !== 1'b1) begin
      failures++; $display("FAIL single_write actual wen=%b addr=%0d data=%h required wen=1 addr=7 data=deadbeef",
                           wen, w_addr, w_data);
    end
    idle();
    checks++;
    if (wen !== 1'b0 || busy_mask !== '0 || obs !== exp_vec()) begin
      failures++; $display("FAIL single_done actual=%h required=%h", obs, exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    int exp_seq[6] = '{1, 9, 2, 10, 3, 11};
    int got_seq[$];
    int first, last, cyc;
    first = -1; last = -1; cyc = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ADDR_W'(i + 1), $urandom, 1'b1, ADDR_W'(i + 9), $urandom, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL b2b_push c%0d actual=%h required=%h", i, obs, exp_vec());
      end
      if (wen) begin got_seq.push_back(int'(w_addr)); if (first < 0) first = cyc; last = cyc; end
      cyc++;
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL b2b_drain c%0d actual=%h required=%h", i, obs, exp_vec());
      end
      if (wen) begin got_seq.push_back(int'(w_addr)); if (first < 0) first = cyc; last = cyc; end
      cyc++;
    end
    checks++;
    if (got_seq.size() != 6 || (last - first) != 5) begin
      failures++; $display("FAIL b2b_count actual=%0d writes span=%0d required=6 writes span=5",
                           got_seq.size(), last - first);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_seq[i] != exp_seq[i]) begin
          failures++; $display("FAIL b2b_order idx%0d actual=%0d required=%0d", i, got_seq[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_full();
    logic [DATA_W-1:0] ad;
    logic [ADDR_W-1:0] aa;
    bit saw_stall;
    saw_stall = 0;
    aa = 5'd12; ad = $urandom;
    for (int i = 0; i < 14; i++) begin
      // Hold the ALU request steady while it cannot be accepted.
      if (aq.size() < QDEPTH) begin aa = ADDR_W'($urandom_range(1, NREG - 1)); ad = $urandom; end
      step(1'b1, aa, ad, 1'b1, ADDR_W'($urandom_range(1, NREG - 1)), $urandom, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL full_push c%0d actual=%h required=%h", i, obs, exp_vec());
      end
      if (alu_ready === 1'b0) saw_stall = 1;
    end
    checks++;
    if (!saw_stall) begin
      failures++; $display("FAIL full_stall actual=never_stalled required=alu_ready_low");
    end
    for (int i = 0; i < 10; i++) begin
      idle();
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL full_drain c%0d actual=%h required=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_zero();
    step(1'b1, 5'd0, 32'h5, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wen !== 1'b0 || busy_mask[0] !== 1'b0 || obs !== exp_vec()) begin
        failures++; $display("FAIL zero_addr c%0d actual=%h required=%h", i, obs, exp_vec());
      end
      idle();
    end
    step(1'b1, 5'd3, 32'h33, 1'b0, '0, '0, 1'b0);
    idle();
    checks++;
    if (wen !== 1'b1 || w_addr !== 5'd3 || w_data !== 32'h33) begin
      failures++; $display("FAIL zero_next actual wen=%b addr=%0d data=%h required wen=1 addr=3 data=33",
                           wen, w_addr, w_data);
    end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++)
      step(1'b1, ADDR_W'(i + 20), $urandom, 1'b1, ADDR_W'(i + 24), $urandom, 1'b0);
    flush = 1'b1; alu_valid = 1'b1; alu_addr = 5'd30;
    #1;
    checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      failures++; $display("FAIL flush_ready actual=%b%b required=00", alu_ready, mem_ready);
    end
    step(1'b1, 5'd30, 32'hF00D, 1'b0, '0, '0, 1'b1);
    flush = 1'b0;
    #1;
    checks++;
    if (wen !== 1'b0 || busy_mask !== '0 || obs !== exp_vec()) begin
      failures++; $display("FAIL flush_after actual=%h required=%h", obs, exp_vec());
    end
    step(1'b1, 5'd14, 32'hABCD, 1'b1, 5'd15, 32'h1234, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL flush_resume c%0d actual=%h required=%h", i, obs, exp_vec());
      end
      idle();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      step(1'b1, ADDR_W'(i + 4), $urandom, 1'b1, ADDR_W'(i + 16), $urandom, 1'b0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (wen !== 1'b0 || busy_mask !== '0 || obs !== exp_vec()) begin
      failures++; $display("FAIL reset_async actual=%h required=%h", obs, exp_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (wen !== 1'b0 || obs !== exp_vec()) begin
        failures++; $display("FAIL reset_discard c%0d actual=%h required=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 6, ADDR_W'($urandom), $urandom,
           $urandom_range(0, 9) < 6, ADDR_W'($urandom), $urandom,
           $urandom_range(0, 99) < 3);
      checks++;
      if (obs !== exp_vec()) begin
        failures++; $display("FAIL random c%0d actual=%h required=%h", i, obs, exp_vec());
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_zero();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
